// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register writer tracking beside the ID stage.
// Drives PC/IF-ID stall, ID-EX bubble/flush and registered EX forward selects.
module hazard_scoreboard #(
    parameter int NREG       = 32,
    parameter int RAW        = 5,
    parameter int MEM_STAGES = 1,
    parameter int FWD_EN     = 1,
    localparam int WB_IDX    = MEM_STAGES + 2,
    localparam int SELW      = $clog2(WB_IDX + 1)
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_id_vld,
    input  logic [RAW-1:0]  i_id_rs1,
    input  logic [RAW-1:0]  i_id_rs2,
    input  logic            i_id_rs1_use,
    input  logic            i_id_rs2_use,
    input  logic [RAW-1:0]  i_id_rd,
    input  logic            i_id_rd_wren,
    input  logic            i_id_is_load,
    input  logic            i_ex_redirect,
    output logic            o_stall_pc,
    output logic            o_stall_if_id,
    output logic            o_bubble_id_ex,
    output logic            o_flush_if_id,
    output logic            o_flush_id_ex,
    output logic [SELW-1:0] o_fwd_rs1_sel,
    output logic [SELW-1:0] o_fwd_rs2_sel
);

    localparam logic [SELW-1:0] WB_POS = SELW'(WB_IDX);
    localparam logic [SELW:0]   WB_EXT = (SELW + 1)'(WB_IDX);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] ld;
    logic [SELW-1:0] pos [NREG];

    logic [SELW:0] chk1;
    logic [SELW:0] chk2;
    logic          haz;
    logic          issue;
    logic          wr_en;

    // Returns {hazard, sel} for one source operand.
    // n is the producer's stage while the consumer sits in EX; a producer
    // already past WB by then has retired, so the operand comes from the
    // register file (sel 0).
    function automatic logic [SELW:0] src_chk(
        input logic            use_i,
        input logic            nz,
        input logic            pnd,
        input logic            lde,
        input logic [SELW-1:0] p
    );
        logic [SELW:0]   n;
        logic            h;
        logic [SELW-1:0] s;
        n = {1'b0, p} + (SELW + 1)'(1);
        h = 1'b0;
        s = '0;
        if (use_i && nz && pnd) begin
            if (FWD_EN == 0) begin
                h = 1'b1;
            end else if (lde && (n < WB_EXT)) begin
                h = 1'b1;
            end else if (n <= WB_EXT) begin
                s = n[SELW-1:0];
            end
        end
        return {h, s};
    endfunction

    // Source checks, hazard and issue decision for the instruction in ID
    always_comb begin
        chk1 = src_chk(i_id_rs1_use, i_id_rs1 != '0, pend[i_id_rs1],
                       ld[i_id_rs1], pos[i_id_rs1]);
        chk2 = src_chk(i_id_rs2_use, i_id_rs2 != '0, pend[i_id_rs2],
                       ld[i_id_rs2], pos[i_id_rs2]);
        haz   = i_id_vld & (chk1[SELW] | chk2[SELW]);
        issue = i_id_vld & ~haz & ~i_ex_redirect;
        wr_en = issue & i_id_rd_wren & (i_id_rd != '0);
    end

    // Control outputs: redirect beats hazard, nothing asserts during reset
    always_comb begin
        o_stall_pc     = haz & ~i_ex_redirect & i_reset_n;
        o_stall_if_id  = haz & ~i_ex_redirect & i_reset_n;
        o_bubble_id_ex = haz & ~i_ex_redirect & i_reset_n;
        o_flush_if_id  = i_ex_redirect & i_reset_n;
        o_flush_id_ex  = i_ex_redirect & i_reset_n;
    end

    // Scoreboard: youngest writer per register, aging one stage per cycle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pend <= '0;
            ld   <= '0;
            for (int r = 0; r < NREG; r++) begin
                pos[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (wr_en && (i_id_rd == RAW'(r))) begin
                    pend[r] <= 1'b1;
                    pos[r]  <= SELW'(1);
                    ld[r]   <= i_id_is_load;
                end else if (pend[r]) begin
                    pos[r] <= pos[r] + SELW'(1);
                    if (pos[r] == WB_POS) begin
                        pend[r] <= 1'b0;
                    end
                end
            end
        end
    end

    // Forward selects travel with the instruction into EX; bubbles get 0
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_fwd_rs1_sel <= '0;
            o_fwd_rs2_sel <= '0;
        end else if (issue) begin
            o_fwd_rs1_sel <= chk1[SELW-1:0];
            o_fwd_rs2_sel <= chk2[SELW-1:0];
        end else begin
            o_fwd_rs1_sel <= '0;
            o_fwd_rs2_sel <= '0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: three configurations (default, MEM_STAGES=2,
// interlock-only) checked every cycle against an in-flight instruction list.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       vld   [3];
    logic [4:0] rs1   [3];
    logic [4:0] rs2   [3];
    logic       rs1u  [3];
    logic       rs2u  [3];
    logic [4:0] rd    [3];
    logic       wren  [3];
    logic       isld  [3];
    logic       redir [3];
    logic       st_pc [3];
    logic       st_if [3];
    logic       bub   [3];
    logic       fl_if [3];
    logic       fl_ex [3];
    logic [1:0] s1_0, s2_0, s1_2, s2_2;
    logic [2:0] s1_1, s2_1;

    hazard_scoreboard #(.NREG(32), .RAW(5), .MEM_STAGES(1), .FWD_EN(1)) u0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_id_vld(vld[0]),
        .i_id_rs1(rs1[0]), .i_id_rs2(rs2[0]),
        .i_id_rs1_use(rs1u[0]), .i_id_rs2_use(rs2u[0]),
        .i_id_rd(rd[0]), .i_id_rd_wren(wren[0]), .i_id_is_load(isld[0]),
        .i_ex_redirect(redir[0]), .o_stall_pc(st_pc[0]),
        .o_stall_if_id(st_if[0]), .o_bubble_id_ex(bub[0]),
        .o_flush_if_id(fl_if[0]), .o_flush_id_ex(fl_ex[0]),
        .o_fwd_rs1_sel(s1_0), .o_fwd_rs2_sel(s2_0));

    hazard_scoreboard #(.NREG(32), .RAW(5), .MEM_STAGES(2), .FWD_EN(1)) u1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_id_vld(vld[1]),
        .i_id_rs1(rs1[1]), .i_id_rs2(rs2[1]),
        .i_id_rs1_use(rs1u[1]), .i_id_rs2_use(rs2u[1]),
        .i_id_rd(rd[1]), .i_id_rd_wren(wren[1]), .i_id_is_load(isld[1]),
        .i_ex_redirect(redir[1]), .o_stall_pc(st_pc[1]),
        .o_stall_if_id(st_if[1]), .o_bubble_id_ex(bub[1]),
        .o_flush_if_id(fl_if[1]), .o_flush_id_ex(fl_ex[1]),
        .o_fwd_rs1_sel(s1_1), .o_fwd_rs2_sel(s2_1));

    hazard_scoreboard #(.NREG(32), .RAW(5), .MEM_STAGES(1), .FWD_EN(0)) u2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_id_vld(vld[2]),
        .i_id_rs1(rs1[2]), .i_id_rs2(rs2[2]),
        .i_id_rs1_use(rs1u[2]), .i_id_rs2_use(rs2u[2]),
        .i_id_rd(rd[2]), .i_id_rd_wren(wren[2]), .i_id_is_load(isld[2]),
        .i_ex_redirect(redir[2]), .o_stall_pc(st_pc[2]),
        .o_stall_if_id(st_if[2]), .o_bubble_id_ex(bub[2]),
        .o_flush_if_id(fl_if[2]), .o_flush_id_ex(fl_ex[2]),
        .o_fwd_rs1_sel(s1_2), .o_fwd_rs2_sel(s2_2));

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dsel(input int c, input bit second);
        logic [31:0] v;
        v = '0;
        case (c)
            0: v = second ? {30'b0, s2_0} : {30'b0, s1_0};
            1: v = second ? {29'b0, s2_1} : {29'b0, s1_1};
            default: v = second ? {30'b0, s2_2} : {30'b0, s1_2};
        endcase
        return v;
    endfunction

    function automatic logic [31:0] dctl(input int c);
        return {27'b0, st_pc[c], st_if[c], bub[c], fl_if[c], fl_ex[c]};
    endfunction

    // Model: list of issued writers with issue cycle; age 1 = EX.
    int wbi [3] = '{3, 4, 3};
    bit fwd [3] = '{1'b1, 1'b1, 1'b0};
    int cyc = 0;
    int n_wr [3] = '{0, 0, 0};
    int         wk  [3][256];
    logic [4:0] wrd [3][256];
    bit         wld [3][256];
    int exp_s1 [3] = '{0, 0, 0};
    int exp_s2 [3] = '{0, 0, 0};
    bit         u_iss [3] = '{0, 0, 0};
    bit         u_w   [3] = '{0, 0, 0};
    bit         u_ld  [3] = '{0, 0, 0};
    logic [4:0] u_rd  [3] = '{5'd0, 5'd0, 5'd0};
    int         u_s1  [3] = '{0, 0, 0};
    int         u_s2  [3] = '{0, 0, 0};

    function automatic void src(input int c, input logic u,
                                input logic [4:0] rs,
                                output bit haz, output int sel);
        int age;
        int stg;
        haz = 1'b0;
        sel = 0;
        if (u !== 1'b1 || rs == 5'd0) return;
        for (int j = n_wr[c] - 1; j >= 0; j--) begin
            if (wrd[c][j] == rs) begin
                age = cyc - wk[c][j];
                if (age >= 1 && age <= wbi[c]) begin
                    stg = age + 1;
                    if (!fwd[c]) haz = 1'b1;
                    else if (wld[c][j] && stg < wbi[c]) haz = 1'b1;
                    else if (stg <= wbi[c]) sel = stg;
                end
                return;
            end
        end
    endfunction

    always @(negedge clk) begin
        bit h1, h2, hz;
        int e1, e2;
        logic sv;
        logic [4:0] ec;
        for (int c = 0; c < 3; c++) begin
            if (rst_n !== 1'b1) begin
                chk($sformatf("c%0d ctl rst", c), dctl(c), 0);
                chk($sformatf("c%0d sel1 rst", c), dsel(c, 0), 0);
                chk($sformatf("c%0d sel2 rst", c), dsel(c, 1), 0);
                u_iss[c] = 1'b0;
            end else begin
                src(c, rs1u[c], rs1[c], h1, e1);
                src(c, rs2u[c], rs2[c], h2, e2);
                hz = vld[c] & (h1 | h2);
                sv = hz & ~redir[c];
                ec = {sv, sv, sv, redir[c], redir[c]};
                chk($sformatf("c%0d ctl cyc%0d", c, cyc), dctl(c), {27'b0, ec});
                chk($sformatf("c%0d sel1 cyc%0d", c, cyc), dsel(c, 0), exp_s1[c]);
                chk($sformatf("c%0d sel2 cyc%0d", c, cyc), dsel(c, 1), exp_s2[c]);
                u_iss[c] = vld[c] & ~hz & ~redir[c];
                u_w[c]   = wren[c];
                u_ld[c]  = isld[c];
                u_rd[c]  = rd[c];
                u_s1[c]  = u_iss[c] ? e1 : 0;
                u_s2[c]  = u_iss[c] ? e2 : 0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                n_wr[c] = 0;
                exp_s1[c] = 0;
                exp_s2[c] = 0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (u_iss[c] && u_w[c] && u_rd[c] != 5'd0 && n_wr[c] < 256) begin
                    wk[c][n_wr[c]]  = cyc;
                    wrd[c][n_wr[c]] = u_rd[c];
                    wld[c][n_wr[c]] = u_ld[c];
                    n_wr[c]++;
                end
                exp_s1[c] = u_s1[c];
                exp_s2[c] = u_s2[c];
            end
            cyc++;
        end
    end

    task automatic clr_in(input int c);
        vld[c] = 0; rs1[c] = 0; rs2[c] = 0; rs1u[c] = 0; rs2u[c] = 0;
        rd[c] = 0; wren[c] = 0; isld[c] = 0; redir[c] = 0;
    endtask

    task automatic set_in(input int c, input logic [4:0] a, input logic ua,
                          input logic [4:0] b, input logic ub,
                          input logic [4:0] d, input logic w, input logic l);
        vld[c] = 1; rs1[c] = a; rs1u[c] = ua; rs2[c] = b; rs2u[c] = ub;
        rd[c] = d; wren[c] = w; isld[c] = l;
    endtask

    task automatic issue(input string nm, input int c,
                         input logic [4:0] a, input logic ua,
                         input logic [4:0] b, input logic ub,
                         input logic [4:0] d, input logic w, input logic l,
                         input int exp_st);
        int st;
        set_in(c, a, ua, b, ub, d, w, l);
        st = 0;
        while (1) begin
            @(negedge clk);
            if (st_pc[c] !== 1'b1) break;
            st++;
            if (st > 20) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        clr_in(c);
        chk({nm, " stalls"}, st, exp_st);
    endtask

    task automatic chk_sel(input string nm, input int c,
                           input int e1, input int e2);
        @(negedge clk);
        chk({nm, " sel1"}, dsel(c, 0), e1);
        chk({nm, " sel2"}, dsel(c, 1), e2);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) clr_in(c);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ctl", dctl(0), 0);
        chk("reset sel", dsel(0, 0), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // add x5 ; add x6,x5,x5
        issue("alu w", 0, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
        issue("alu use", 0, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        chk_sel("alu fwd", 0, 2, 2);
        idle(4);

        // lw x5 ; add x7,x5,x0
        issue("lw w", 0, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
        issue("lw use", 0, 5'd5, 1, 5'd0, 1, 5'd7, 1, 0, 1);
        chk_sel("lw fwd", 0, 3, 0);
        idle(4);

        // lw x5 ; add x5 ; add x8,x5 -> youngest writer
        issue("yng lw", 0, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
        issue("yng add", 0, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
        issue("yng use", 0, 5'd5, 1, 5'd0, 0, 5'd8, 1, 0, 0);
        chk_sel("yng fwd", 0, 2, 0);
        idle(4);

        // writes to x0 never tracked
        issue("x0 lw", 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);
        issue("x0 use", 0, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0);
        chk_sel("x0 fwd", 0, 0, 0);
        idle(4);

        // load-use hazard with redirect in the same cycle
        issue("rd lw", 0, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
        set_in(0, 5'd5, 1, 5'd0, 0, 5'd8, 1, 0);
        redir[0] = 1;
        @(negedge clk);
        chk("redirect ctl", dctl(0), 32'b00011);
        @(posedge clk);
        #1;
        clr_in(0);
        issue("killed rd", 0, 5'd8, 1, 5'd8, 1, 5'd9, 1, 0, 0);
        chk_sel("killed fwd", 0, 0, 0);
        idle(4);

        // reset in the middle of a load-use stall
        issue("rst lw", 0, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
        set_in(0, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0);
        @(negedge clk);
        chk("pre-rst stall", {31'b0, st_pc[0]}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-rst ctl", dctl(0), 0);
        chk("mid-rst sel", dsel(0, 0), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue("post-rst", 0, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0, 0);
        chk_sel("post-rst fwd", 0, 0, 0);
        idle(2);

        // MEM_STAGES = 2
        issue("m2 lw", 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
        issue("m2 use", 1, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0, 2);
        chk_sel("m2 fwd", 1, 4, 0);
        idle(5);
        issue("m2 lw2", 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
        issue("m2 indep", 1, 5'd6, 1, 5'd4, 1, 5'd7, 1, 0, 0);
        chk_sel("m2 indep", 1, 0, 0);
        idle(5);

        // interlock only
        issue("il w", 2, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
        issue("il use", 2, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 3);
        chk_sel("il sel", 2, 0, 0);
        issue("il x0w", 2, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0);
        issue("il x0use", 2, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0, 0);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
